// File: rtl/bitrev_pkg.sv
// Shared types and constants for the bit-reversal job scheduler.
package bitrev_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int JOBS_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    WAIT_DONE,
    RELEASE
  } sched_state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import bitrev_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  int k;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bitrev_job_scheduler.sv
// Round-robin job scheduler sharing one fifo2axis bridge and bit-reversal
// accelerator between NREQ requesters. Optional WAIT_DONE watchdog is
// enabled by defining BITREV_SCHED_TIMEOUT_EN.
module bitrev_job_scheduler
  import bitrev_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int JOB_WORDS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ-1:0]            wr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] din_i,
  output logic [NREQ-1:0]            gnt_o,
  output logic [NREQ-1:0]            done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [JOBS_W-1:0]          jobs_o,
  output logic                       bridge_start,
  output logic                       bridge_write,
  output logic [DATA_WIDTH-1:0]      bridge_din,
  input  logic                       accel_tlast
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(JOB_WORDS + 1);

  sched_state_e          state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [JOBS_W-1:0]     jobs_q, jobs_d;
  logic                  start_q, start_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [NREQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      ptr_next;

`ifdef BITREV_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign ptr_next = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    jobs_d  = jobs_q;
    din_d   = din_q;
    done_d  = '0;
    err_d   = 1'b0;
    write_d = 1'b0;
`ifdef BITREV_SCHED_TIMEOUT_EN
    to_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (wr_i[idx_q]) begin
          write_d = 1'b1;
          din_d   = din_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(JOB_WORDS - 1)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
`ifdef BITREV_SCHED_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        if (accel_tlast) begin
          done_d  = gnt_q;
          jobs_d  = jobs_q + JOBS_W'(1);
          ptr_d   = ptr_next;
          state_d = RELEASE;
        end
`ifdef BITREV_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          ptr_d   = ptr_next;
          state_d = RELEASE;
        end
`endif
      end
      RELEASE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  // Single register bank for the FSM and all of its outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      jobs_q  <= '0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      din_q   <= '0;
`ifdef BITREV_SCHED_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      jobs_q  <= jobs_d;
      start_q <= start_d;
      write_q <= write_d;
      din_q   <= din_d;
`ifdef BITREV_SCHED_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign jobs_o       = jobs_q;
  assign bridge_start = start_q;
  assign bridge_write = write_q;
  assign bridge_din   = din_q;

endmodule
